// File: rtl/pms_stage_pkg.sv
// Shared definitions for the pre-memory stage:
// FSM states, exception codes and access-size codes.
package pms_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_DONE = 2'd3
    } pms_state_e;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Everything the stage keeps about one slot once the bundle is latched.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exc;
        logic [4:0]  adexc;
    } pms_slot_t;

    function automatic logic [4:0] adexc_code(
        input logic mis,
        input logic we
    );
        if (!mis)
            return 5'h00;
        return we ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/pms_stage_mem_encode.sv
// Per-slot store encoder: byte strobes, lane-replicated
// write data and alignment check for one memory access.
module pms_mem_encode
    import pms_stage_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        mis_o
);

    logic [3:0] strb;

    // Decode size and low address bits into strobes and lanes.
    always_comb begin
        strb    = 4'b1111;
        wdata_o = wdata_i;
        mis_o   = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                strb    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                strb    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                mis_o   = addr_i[0];
            end
            default: begin
                strb    = 4'b1111;
                wdata_o = wdata_i;
                mis_o   = |addr_i;
            end
        endcase
    end

    assign wstrb_o = we_i ? strb : 4'b0000;

endmodule

// File: rtl/pms_stage.sv
// Pre-memory stage: latches an EXE bundle, checks alignment and
// issues up to two in-order data-SRAM requests before handing off.
module pms_stage
    import pms_stage_pkg::*;
#(
    parameter int PAYLOAD_W = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_all,
    input  logic                 es_to_pms_valid,
    output logic                 pms_allowin,
    input  logic [PAYLOAD_W-1:0] es_payload,
    input  logic                 es_i1_valid,
    input  logic                 es_i1_re,
    input  logic                 es_i1_we,
    input  logic [1:0]           es_i1_size,
    input  logic [31:0]          es_i1_addr,
    input  logic [31:0]          es_i1_wdata,
    input  logic                 es_i1_exc,
    input  logic                 es_i2_valid,
    input  logic                 es_i2_re,
    input  logic                 es_i2_we,
    input  logic [1:0]           es_i2_size,
    input  logic [31:0]          es_i2_addr,
    input  logic [31:0]          es_i2_wdata,
    input  logic                 es_i2_exc,
    output logic                 data_req,
    output logic                 data_wr,
    output logic [1:0]           data_size,
    output logic [31:0]          data_addr,
    output logic [3:0]           data_wstrb,
    output logic [31:0]          data_wdata,
    input  logic                 data_addr_ok,
    input  logic                 ms_allowin,
    output logic                 pms_to_ms_valid,
    output logic [PAYLOAD_W-1:0] pms_payload,
    output logic                 pms_i1_exc,
    output logic [4:0]           pms_i1_adexc,
    output logic                 pms_i1_req,
    output logic                 pms_i2_exc,
    output logic [4:0]           pms_i2_adexc,
    output logic                 pms_i2_req,
    output logic                 pms_discard
);

    pms_state_e           state_q, state_d;
    logic                 valid_q, valid_d;
    logic                 hold_q, hold_d;
    logic                 discard_q, discard_d;
    logic                 req1_q, req1_d;
    logic                 req2_q, req2_d;
    logic                 need2_q, need2_d;
    pms_slot_t            s1_q, s1_d;
    pms_slot_t            s2_q, s2_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    logic [3:0]  i1_strb, i2_strb;
    logic [31:0] i1_wd, i2_wd;
    logic        i1_mis_raw, i2_mis_raw;
    logic        i1_mem, i2_mem;
    logic        i1_mis, i2_mis;
    logic        i1_fexc, i2_fexc;
    logic        i1_need, i2_need;
    logic        ready_go, latch, accept, leave;
    pms_slot_t   cur;

    pms_mem_encode u_enc1 (
        .size_i  (es_i1_size),
        .addr_i  (es_i1_addr[1:0]),
        .wdata_i (es_i1_wdata),
        .we_i    (es_i1_we),
        .wstrb_o (i1_strb),
        .wdata_o (i1_wd),
        .mis_o   (i1_mis_raw)
    );

    pms_mem_encode u_enc2 (
        .size_i  (es_i2_size),
        .addr_i  (es_i2_addr[1:0]),
        .wdata_i (es_i2_wdata),
        .we_i    (es_i2_we),
        .wstrb_o (i2_strb),
        .wdata_o (i2_wd),
        .mis_o   (i2_mis_raw)
    );

    // Slot 2 never touches memory once slot 1 has excepted.
    assign i1_mem  = es_i1_valid & (es_i1_re | es_i1_we);
    assign i2_mem  = es_i2_valid & (es_i2_re | es_i2_we);
    assign i1_mis  = i1_mem & i1_mis_raw;
    assign i2_mis  = i2_mem & i2_mis_raw;
    assign i1_fexc = es_i1_valid & (es_i1_exc | i1_mis);
    assign i2_fexc = es_i2_valid & (es_i2_exc | i2_mis);
    assign i1_need = i1_mem & !i1_fexc;
    assign i2_need = i2_mem & !i2_fexc & !i1_fexc;

    assign ready_go        = (state_q == ST_DONE);
    assign data_req        = valid_q
                           & ((state_q == ST_S1) | (state_q == ST_S2));
    assign pms_allowin     = !valid_q
                           | (ready_go & ms_allowin & !hold_q);
    assign pms_to_ms_valid = valid_q & ready_go;
    assign latch           = es_to_pms_valid & pms_allowin & !clear_all;
    assign accept          = data_req & data_addr_ok;
    assign leave           = pms_to_ms_valid & ms_allowin;

    // Select the slot whose request is currently on the SRAM bus.
    always_comb begin
        cur = s1_q;
        if (state_q == ST_S2)
            cur = s2_q;
    end

    assign data_wr      = cur.we;
    assign data_size    = cur.size;
    assign data_addr    = cur.addr;
    assign data_wstrb   = cur.wstrb;
    assign data_wdata   = cur.wdata;
    assign pms_payload  = payload_q;
    assign pms_i1_exc   = s1_q.exc;
    assign pms_i1_adexc = s1_q.adexc;
    assign pms_i1_req   = req1_q;
    assign pms_i2_exc   = s2_q.exc;
    assign pms_i2_adexc = s2_q.adexc;
    assign pms_i2_req   = req2_q;
    assign pms_discard  = discard_q;

    // Next-state: flush handling first, then request FSM and bundle latch.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        discard_d = 1'b0;
        req1_d    = req1_q;
        req2_d    = req2_q;
        need2_d   = need2_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        payload_d = payload_q;

        if (hold_q) begin
            if (accept) begin
                discard_d = 1'b1;
                hold_d    = 1'b0;
                valid_d   = 1'b0;
                state_d   = ST_IDLE;
            end
        end else if (clear_all) begin
            if (data_req && !data_addr_ok) begin
                hold_d = 1'b1;
            end else begin
                discard_d = accept;
                valid_d   = 1'b0;
                state_d   = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_S1: begin
                    if (accept) begin
                        req1_d  = 1'b1;
                        state_d = need2_q ? ST_S2 : ST_DONE;
                    end
                end
                ST_S2: begin
                    if (accept) begin
                        req2_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (leave) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase

            if (latch) begin
                valid_d    = 1'b1;
                req1_d     = 1'b0;
                req2_d     = 1'b0;
                need2_d    = i2_need;
                payload_d  = es_payload;
                s1_d.we    = es_i1_we;
                s1_d.size  = es_i1_size;
                s1_d.addr  = es_i1_addr;
                s1_d.wdata = i1_wd;
                s1_d.wstrb = i1_strb;
                s1_d.exc   = i1_fexc;
                s1_d.adexc = adexc_code(i1_mis, es_i1_we);
                s2_d.we    = es_i2_we;
                s2_d.size  = es_i2_size;
                s2_d.addr  = es_i2_addr;
                s2_d.wdata = i2_wd;
                s2_d.wstrb = i2_strb;
                s2_d.exc   = i2_fexc;
                s2_d.adexc = adexc_code(i2_mis, es_i2_we);
                if (i1_need)
                    state_d = ST_S1;
                else if (i2_need)
                    state_d = ST_S2;
                else
                    state_d = ST_DONE;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            hold_q    <= 1'b0;
            discard_q <= 1'b0;
            req1_q    <= 1'b0;
            req2_q    <= 1'b0;
            need2_q   <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            hold_q    <= hold_d;
            discard_q <= discard_d;
            req1_q    <= req1_d;
            req2_q    <= req2_d;
            need2_q   <= need2_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: tb/tb_pms_stage.sv
// Directed bench for pms_stage: handshake, encoding,
// alignment exceptions, stalls, flushes and reset.
module tb_pms_stage;

    localparam int PW = 256;

    logic          clk = 1'b0;
    logic          reset, clear_all, es_to_pms_valid, pms_allowin;
    logic [PW-1:0] es_payload;
    logic          es_i1_valid, es_i1_re, es_i1_we, es_i1_exc;
    logic [1:0]    es_i1_size;
    logic [31:0]   es_i1_addr, es_i1_wdata;
    logic          es_i2_valid, es_i2_re, es_i2_we, es_i2_exc;
    logic [1:0]    es_i2_size;
    logic [31:0]   es_i2_addr, es_i2_wdata;
    logic          data_req, data_wr, data_addr_ok, ms_allowin;
    logic [1:0]    data_size;
    logic [31:0]   data_addr, data_wdata;
    logic [3:0]    data_wstrb;
    logic          pms_to_ms_valid, pms_discard;
    logic [PW-1:0] pms_payload;
    logic          pms_i1_exc, pms_i1_req, pms_i2_exc, pms_i2_req;
    logic [4:0]    pms_i1_adexc, pms_i2_adexc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pms_stage #(.PAYLOAD_W(PW)) dut (
        .clk             (clk),
        .reset           (reset),
        .clear_all       (clear_all),
        .es_to_pms_valid (es_to_pms_valid),
        .pms_allowin     (pms_allowin),
        .es_payload      (es_payload),
        .es_i1_valid     (es_i1_valid),
        .es_i1_re        (es_i1_re),
        .es_i1_we        (es_i1_we),
        .es_i1_size      (es_i1_size),
        .es_i1_addr      (es_i1_addr),
        .es_i1_wdata     (es_i1_wdata),
        .es_i1_exc       (es_i1_exc),
        .es_i2_valid     (es_i2_valid),
        .es_i2_re        (es_i2_re),
        .es_i2_we        (es_i2_we),
        .es_i2_size      (es_i2_size),
        .es_i2_addr      (es_i2_addr),
        .es_i2_wdata     (es_i2_wdata),
        .es_i2_exc       (es_i2_exc),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wstrb      (data_wstrb),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .ms_allowin      (ms_allowin),
        .pms_to_ms_valid (pms_to_ms_valid),
        .pms_payload     (pms_payload),
        .pms_i1_exc      (pms_i1_exc),
        .pms_i1_adexc    (pms_i1_adexc),
        .pms_i1_req      (pms_i1_req),
        .pms_i2_exc      (pms_i2_exc),
        .pms_i2_adexc    (pms_i2_adexc),
        .pms_i2_req      (pms_i2_req),
        .pms_discard     (pms_discard)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_es();
        es_to_pms_valid = 0;
        es_payload = '0;
        es_i1_valid = 0; es_i1_re = 0; es_i1_we = 0; es_i1_exc = 0;
        es_i1_size = 0; es_i1_addr = 0; es_i1_wdata = 0;
        es_i2_valid = 0; es_i2_re = 0; es_i2_we = 0; es_i2_exc = 0;
        es_i2_size = 0; es_i2_addr = 0; es_i2_wdata = 0;
    endtask

    task automatic slot1(input logic re, input logic we,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
        es_to_pms_valid = 1;
        es_i1_valid = 1; es_i1_re = re; es_i1_we = we;
        es_i1_size = sz; es_i1_addr = a; es_i1_wdata = d;
    endtask

    task automatic slot2(input logic re, input logic we,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
        es_i2_valid = 1; es_i2_re = re; es_i2_we = we;
        es_i2_size = sz; es_i2_addr = a; es_i2_wdata = d;
    endtask

    initial begin
        clr_es();
        clear_all = 0; data_addr_ok = 0; ms_allowin = 1;
        reset = 1;
        repeat (2) step();
        chk("rst_req", {31'b0, data_req}, 0);
        chk("rst_vld", {31'b0, pms_to_ms_valid}, 0);
        chk("rst_disc", {31'b0, pms_discard}, 0);
        chk("rst_allowin", {31'b0, pms_allowin}, 1);
        reset = 0;

        // sw 0x1000, addr_ok immediately
        slot1(0, 1, 2'd2, 32'h1000, 32'hA5A5_1234);
        es_payload = {8{32'hC0DE_0001}};
        data_addr_ok = 1;
        step();
        clr_es();
        chk("t1_req", {31'b0, data_req}, 1);
        chk("t1_wr", {31'b0, data_wr}, 1);
        chk("t1_strb", {28'b0, data_wstrb}, 32'hF);
        chk("t1_addr", data_addr, 32'h1000);
        chk("t1_wdata", data_wdata, 32'hA5A5_1234);
        chk("t1_vld_early", {31'b0, pms_to_ms_valid}, 0);
        step();
        chk("t1_vld", {31'b0, pms_to_ms_valid}, 1);
        chk("t1_req1", {31'b0, pms_i1_req}, 1);
        chk("t1_req_off", {31'b0, data_req}, 0);
        chk("t1_payload", pms_payload[31:0], 32'hC0DE_0001);
        data_addr_ok = 0;
        step();
        chk("t1_left", {31'b0, pms_to_ms_valid}, 0);
        chk("t1_allowin", {31'b0, pms_allowin}, 1);

        // sb 0x1003 then lw 0x2000
        slot1(0, 1, 2'd0, 32'h1003, 32'h0000_0012);
        slot2(1, 0, 2'd2, 32'h2000, 32'h0);
        data_addr_ok = 1;
        step();
        clr_es();
        chk("t2_req1", {31'b0, data_req}, 1);
        chk("t2_strb1", {28'b0, data_wstrb}, 32'h8);
        chk("t2_wdata1", data_wdata, 32'h1212_1212);
        chk("t2_addr1", data_addr, 32'h1003);
        chk("t2_size1", {30'b0, data_size}, 0);
        step();
        chk("t2_req2", {31'b0, data_req}, 1);
        chk("t2_wr2", {31'b0, data_wr}, 0);
        chk("t2_addr2", data_addr, 32'h2000);
        chk("t2_strb2", {28'b0, data_wstrb}, 0);
        chk("t2_vld_early", {31'b0, pms_to_ms_valid}, 0);
        chk("t2_flag1", {31'b0, pms_i1_req}, 1);
        step();
        chk("t2_vld", {31'b0, pms_to_ms_valid}, 1);
        chk("t2_flag2", {31'b0, pms_i2_req}, 1);
        ms_allowin = 0; data_addr_ok = 0;
        #1;
        chk("t2_stall_allowin", {31'b0, pms_allowin}, 0);
        step();
        chk("t2_stall_vld", {31'b0, pms_to_ms_valid}, 1);
        ms_allowin = 1;
        step();
        chk("t2_left", {31'b0, pms_to_ms_valid}, 0);

        // lh 0x1001 misaligned, slot2 sw suppressed
        slot1(1, 0, 2'd1, 32'h1001, 32'h0);
        slot2(0, 1, 2'd2, 32'h3000, 32'h55);
        step();
        chk("t3_noreq", {31'b0, data_req}, 0);
        chk("t3_vld", {31'b0, pms_to_ms_valid}, 1);
        chk("t3_exc1", {31'b0, pms_i1_exc}, 1);
        chk("t3_adel", {27'b0, pms_i1_adexc}, 32'h04);
        chk("t3_req1", {31'b0, pms_i1_req}, 0);
        chk("t3_req2", {31'b0, pms_i2_req}, 0);
        chk("t3_adexc2", {27'b0, pms_i2_adexc}, 0);
        clr_es();
        slot1(0, 1, 2'd2, 32'h1002, 32'h0);
        step();
        clr_es();
        chk("t3_ades", {27'b0, pms_i1_adexc}, 32'h05);
        chk("t3b_exc1", {31'b0, pms_i1_exc}, 1);
        chk("t3b_vld", {31'b0, pms_to_ms_valid}, 1);
        chk("t3b_noreq", {31'b0, data_req}, 0);
        step();

        // lw 0x4000, addr_ok withheld for 4 cycles
        slot1(1, 0, 2'd2, 32'h4000, 32'h0);
        data_addr_ok = 0;
        step();
        clr_es();
        for (int i = 0; i < 4; i++) begin
            chk("t4_req", {31'b0, data_req}, 1);
            chk("t4_addr", data_addr, 32'h4000);
            chk("t4_size", {30'b0, data_size}, 2);
            chk("t4_allowin", {31'b0, pms_allowin}, 0);
            step();
        end
        data_addr_ok = 1;
        step();
        chk("t4_vld", {31'b0, pms_to_ms_valid}, 1);
        chk("t4_flag1", {31'b0, pms_i1_req}, 1);
        data_addr_ok = 0;
        step();

        // flush while request pending, addr_ok two cycles later
        slot1(0, 1, 2'd2, 32'h5004, 32'hDEAD_BEEF);
        step();
        clr_es();
        clear_all = 1;
        #1;
        chk("t5_req0", {31'b0, data_req}, 1);
        step();
        clear_all = 0;
        chk("t5_req1", {31'b0, data_req}, 1);
        chk("t5_addr", data_addr, 32'h5004);
        chk("t5_wdata", data_wdata, 32'hDEAD_BEEF);
        chk("t5_allowin1", {31'b0, pms_allowin}, 0);
        chk("t5_nodisc", {31'b0, pms_discard}, 0);
        step();
        chk("t5_req2", {31'b0, data_req}, 1);
        chk("t5_allowin2", {31'b0, pms_allowin}, 0);
        data_addr_ok = 1;
        step();
        data_addr_ok = 0;
        chk("t5_disc", {31'b0, pms_discard}, 1);
        chk("t5_allowin", {31'b0, pms_allowin}, 1);
        chk("t5_vld", {31'b0, pms_to_ms_valid}, 0);
        chk("t5_req_off", {31'b0, data_req}, 0);
        step();
        chk("t5_disc_once", {31'b0, pms_discard}, 0);

        // reset while in S2
        slot1(0, 1, 2'd0, 32'h1003, 32'h12);
        slot2(1, 0, 2'd2, 32'h2000, 32'h0);
        data_addr_ok = 1;
        step();
        clr_es();
        step();
        data_addr_ok = 0;
        chk("t6_s2_req", {31'b0, data_req}, 1);
        chk("t6_s2_wr", {31'b0, data_wr}, 0);
        reset = 1;
        step();
        reset = 0;
        chk("t6_req", {31'b0, data_req}, 0);
        chk("t6_vld", {31'b0, pms_to_ms_valid}, 0);
        chk("t6_allowin", {31'b0, pms_allowin}, 1);
        chk("t6_flag2", {31'b0, pms_i2_req}, 0);
        step();
        chk("t6_idle", {31'b0, data_req}, 0);

        // flush with no request outstanding
        slot1(0, 0, 2'd2, 32'h0, 32'h0);
        ms_allowin = 0;
        step();
        clr_es();
        chk("t7_vld", {31'b0, pms_to_ms_valid}, 1);
        chk("t7_noreq", {31'b0, data_req}, 0);
        clear_all = 1;
        step();
        clear_all = 0;
        ms_allowin = 1;
        chk("t7_flushed", {31'b0, pms_to_ms_valid}, 0);
        chk("t7_allowin", {31'b0, pms_allowin}, 1);
        chk("t7_nodisc", {31'b0, pms_discard}, 0);

        // flush in the same cycle as addr_ok
        slot1(1, 0, 2'd2, 32'h6000, 32'h0);
        data_addr_ok = 1;
        step();
        clr_es();
        clear_all = 1;
        #1;
        chk("t8_req", {31'b0, data_req}, 1);
        step();
        clear_all = 0; data_addr_ok = 0;
        chk("t8_disc", {31'b0, pms_discard}, 1);
        chk("t8_vld", {31'b0, pms_to_ms_valid}, 0);
        chk("t8_req_off", {31'b0, data_req}, 0);
        step();
        chk("t8_disc_once", {31'b0, pms_discard}, 0);

        // sh 0x7002
        slot1(0, 1, 2'd1, 32'h7002, 32'h0000_BEEF);
        data_addr_ok = 1;
        step();
        clr_es();
        chk("t9_strb", {28'b0, data_wstrb}, 32'hC);
        chk("t9_wdata", data_wdata, 32'hBEEF_BEEF);
        chk("t9_size", {30'b0, data_size}, 1);
        step();
        data_addr_ok = 0;
        chk("t9_vld", {31'b0, pms_to_ms_valid}, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
